parity_check_sched: RTL and testbench
=====================================

Name: parity_check_sched

Overview:
- Shares one 4-bit even-parity checker between NREQ requesters using round-robin arbitration.
- Each requester presents a data nibble {x,y,z,p} and holds req.
- The block grants one requester, latches its nibble, runs the check, and reports pass/fail with the requester ID.
- Keeps a saturating error counter and per-requester sticky error flags; sits between the requester ports and the shared parity checker datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNT_W, 8, error counter width.
- ID_W, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  NREQ  per-requester check request; held until the matching gnt bit is seen.
- data  input  4*NREQ  per-requester nibble; slice i = data[4i+3:4i] = {x,y,z,p}, with x at the MSB.
- clr  input  1  synchronous clear of err_cnt and err_flag.
- gnt  output  NREQ  one-hot grant, one-cycle pulse.
- done  output  1  one-cycle pulse when a result is valid.
- err  output  1  parity result; 1 = odd number of ones, valid with done.
- done_id  output  ID_W  requester index of the result, valid with done.
- err_cnt  output  CNT_W  saturating count of failed checks.
- err_flag  output  NREQ  sticky per-requester error flags.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr pointer=0, and every output is 0 (gnt, done, err, done_id, err_cnt, err_flag). The operand register is also 0.
- States: IDLE -> GRANT -> CHECK -> DONE -> IDLE.
- IDLE
  - If req != 0, select the first set bit searching from the rr pointer upward, modulo NREQ.
  - Register the one-hot gnt and the selected id; go to GRANT.
  - Otherwise remain in IDLE.
- GRANT
  - gnt is high for exactly this cycle.
  - On the closing edge, latch data slice[id] into the operand register; go to CHECK.
  - Data is captured even if req[id] dropped during GRANT.
- CHECK
  - The operand drives the parity_check4 sub-module.
  - Register its output as err; register done_id=id; go to DONE.
- DONE
  - done=1 for this cycle; err and done_id are valid.
  - rr pointer <= (id+1) mod NREQ.
  - If err: err_cnt increments, saturating at 2^CNT_W-1, and err_flag[id] <= 1. Go to IDLE.
- Latency and throughput:
  - req seen in IDLE at edge n gives gnt high in cycle n+1 and done high in cycle n+3.
  - Maximum throughput is one check per 4 cycles. Back-to-back requests re-arbitrate in IDLE, with no bypass.
- Outside DONE, done=0; err and done_id hold their last values.
- A requester still asserting req after its gnt is treated as a new request. It is served again only after every other pending requester, because of round-robin fairness.
- clr
  - When clr=1, err_cnt and err_flag go to 0 on the next edge.
  - If clr and a DONE update coincide, clr wins and that error is not recorded.
  - clr does not affect the FSM.
- Reset mid-operation aborts any grant in flight: no done is produced, and the requester must re-request.
- Parity function: err = x^y^z^p. Even parity, including all zeros, gives err=0.
- Output timing: all outputs are driven from registers, with no combinational path from inputs to outputs.

Decomposition:
- Shared package parity_sched_pkg holds:
  - the state enum (IDLE, GRANT, CHECK, DONE);
  - the nibble field constants for x, y, z and p bit positions;
  - a clog2 helper for ID_W.
- One sub-module, parity_check4:
  - purely combinational;
  - inputs x,y,z,p; output check = x^y^z^p;
  - instantiated once in the CHECK path.
- The round-robin selector stays inline in the top-level module.

Test Plan:
- Reset release, then req=0001 with data[3:0]=4'b1010: gnt=0001 one cycle later, done two cycles after gnt, err=0, done_id=0, err_cnt=0.
- req[2]=1 with data slice2=4'b0111: err=1, done_id=2, err_cnt=1, err_flag=0100.
- req=1111 held continuously with all slices 4'b0001: grants in order 0,1,2,3,0 spaced 4 cycles apart; err_cnt=5 after 5 dones; err_flag=1111.
- Force 300 failing checks with CNT_W=8: err_cnt saturates at 255. Then pulse clr in the same cycle as a failing done: err_cnt=0 and err_flag=0 next cycle, and the error is not counted.
- Assert rst during CHECK: all outputs are 0 immediately; no done follows; the next request is served starting from requester 0.
- Drop req[1] during its GRANT cycle with data=4'b1100: the check still completes with err=0 and done_id=1, and no second grant is issued to requester 1.

Source files
------------

// File: rtl/parity_sched_pkg.sv
// Shared types and constants for the round-robin shared parity checker.
// Nibble layout is {x,y,z,p} with x at the MSB.
package parity_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NIB_W = 4;
    localparam int X_BIT = 3;
    localparam int Y_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int P_BIT = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/parity_check4.sv
// Combinational 4-bit parity: check is 1 when the nibble has an odd number of ones.
module parity_check4 (
    input  logic x,
    input  logic y,
    input  logic z,
    input  logic p,
    output logic check
);

    assign check = x ^ y ^ z ^ p;

endmodule

// File: rtl/parity_check_sched.sv
// Round-robin scheduler sharing one parity checker between NREQ requesters,
// with a saturating error counter and sticky per-requester error flags.
module parity_check_sched
    import parity_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8,
    parameter int ID_W  = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NIB_W*NREQ-1:0] data,
    input  logic                  clr,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic                  err,
    output logic [ID_W-1:0]       done_id,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [NREQ-1:0]       err_flag
);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr;
    logic [ID_W-1:0]   id;
    logic [NIB_W-1:0]  operand;
    logic              check;

    logic              sel_vld;
    logic [ID_W-1:0]   sel_id;
    logic [NREQ-1:0]   sel_oh;

    // First requester at or above rr, wrapping modulo NREQ.
    always_comb begin : arb
        int unsigned idx;
        idx     = 0;
        sel_vld = 1'b0;
        sel_id  = '0;
        sel_oh  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr) + k) % NREQ;
            if (!sel_vld && req[idx]) begin
                sel_vld     = 1'b1;
                sel_id      = ID_W'(idx);
                sel_oh[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = GRANT;
            GRANT:   state_nxt = CHECK;
            CHECK:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    parity_check4 u_chk (
        .x     (operand[X_BIT]),
        .y     (operand[Y_BIT]),
        .z     (operand[Z_BIT]),
        .p     (operand[P_BIT]),
        .check (check)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            done_id <= '0;
            id      <= '0;
            rr      <= '0;
            operand <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gnt <= sel_oh;
                        id  <= sel_id;
                    end
                end
                // Captured regardless of whether req[id] is still up.
                GRANT: operand <= data[NIB_W*id +: NIB_W];
                CHECK: begin
                    err     <= check;
                    done_id <= id;
                    done    <= 1'b1;
                end
                DONE: rr <= (id == ID_W'(NREQ - 1)) ? '0 : id + ID_W'(1);
                default: ;
            endcase
        end
    end

    // clr takes priority over an error being recorded on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt  <= '0;
            err_flag <= '0;
        end else if (clr) begin
            err_cnt  <= '0;
            err_flag <= '0;
        end else if (state == DONE && err) begin
            if (err_cnt != {CNT_W{1'b1}})
                err_cnt <= err_cnt + CNT_W'(1);
            err_flag[id] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_check_sched.sv
// Bench for parity_check_sched: transaction-schedule model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_parity_check_sched;

    localparam int NREQ  = 4;
    localparam int CNT_W = 8;
    localparam int ID_W  = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [4*NREQ-1:0]   data;
    logic                clr;
    logic [NREQ-1:0]     gnt;
    logic                done;
    logic                err;
    logic [ID_W-1:0]     done_id;
    logic [CNT_W-1:0]    err_cnt;
    logic [NREQ-1:0]     err_flag;

    int nvec  = 0;
    int fails = 0;

    parity_check_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .clr      (clr),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .done_id  (done_id),
        .err_cnt  (err_cnt),
        .err_flag (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an accepted request at edge t gives gnt after t, data capture at
    // t+1, done after t+2, bookkeeping at t+3; next arbitration at t+4.
    int              cyc = 0;
    int              t_acc = 0;
    bit              busy = 0;
    int              m_id = 0;
    int              m_rr = 0;
    int              sel;
    logic [3:0]      m_nib = '0;
    logic [NREQ-1:0] m_gnt = '0;
    logic            m_done = 0;
    logic            m_err = 0;
    logic [ID_W-1:0] m_did = '0;
    int              m_cnt = 0;
    logic [NREQ-1:0] m_flag = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy = 0; m_rr = 0; m_nib = '0; m_gnt = '0; m_done = 0;
            m_err = 0; m_did = '0; m_cnt = 0; m_flag = '0; m_id = 0;
        end else begin
            cyc++;
            m_gnt  = '0;
            m_done = 0;
            if (!busy) begin
                sel = -1;
                for (int k = 0; k < NREQ; k++)
                    if (sel < 0 && req[(m_rr + k) % NREQ]) sel = (m_rr + k) % NREQ;
                if (sel >= 0) begin
                    m_id = sel;
                    m_gnt[m_id] = 1'b1;
                    busy = 1;
                    t_acc = cyc;
                end
            end else begin
                case (cyc - t_acc)
                    1: m_nib = data[4*m_id +: 4];
                    2: begin
                        m_done = 1;
                        m_err  = ^m_nib;
                        m_did  = ID_W'(m_id);
                    end
                    default: begin
                        if (m_err) begin
                            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                            m_flag[m_id] = 1'b1;
                        end
                        m_rr = (m_id + 1) % NREQ;
                        busy = 0;
                    end
                endcase
            end
            if (clr) begin
                m_cnt  = 0;
                m_flag = '0;
            end
        end
    end

    always @(negedge clk) begin
        nvec++;
        if (gnt !== m_gnt || done !== m_done || err !== m_err || done_id !== m_did ||
            err_cnt !== CNT_W'(m_cnt) || err_flag !== m_flag) begin
            fails++;
            $display("FAIL model t=%0t got gnt=%b done=%b err=%b id=%0d cnt=%0d flag=%b want gnt=%b done=%b err=%b id=%0d cnt=%0d flag=%b",
                     $time, gnt, done, err, done_id, err_cnt, err_flag,
                     m_gnt, m_done, m_err, m_did, m_cnt, m_flag);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Raise req, drop the granted bit once gnt is seen, wait for done.
    task automatic run_req(input logic [NREQ-1:0] r, input logic [4*NREQ-1:0] d,
                           output int gcyc, output int dcyc, output logic [NREQ-1:0] g,
                           output logic e, output logic [ID_W-1:0] did);
        @(negedge clk); #1 req = r; data = d;
        gcyc = -1; dcyc = -1; g = '0; e = 1'bx; did = 'x;
        for (int k = 1; k <= 20 && dcyc < 0; k++) begin
            @(negedge clk);
            if (gnt != 0 && gcyc < 0) begin
                gcyc = k; g = gnt;
                #1 req = req & ~g;
            end
            if (done) begin dcyc = k; e = err; did = done_id; end
        end
        if (dcyc < 0) begin
            fails++;
            $display("FAIL run_req timeout got=no_done want=done");
        end
        req = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst = 1'b1; req = '0; clr = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : stim
        int gc, dc, ng, nd, anyg;
        int gid[5];
        int gt[5];
        logic [NREQ-1:0] g;
        logic e;
        logic [ID_W-1:0] did;

        rst = 1'b1; req = '0; data = '0; clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {gnt, done, err, done_id, err_cnt, err_flag}, 0);
        #1 rst = 1'b0;

        // single request, even parity
        run_req(4'b0001, 16'h000A, gc, dc, g, e, did);
        chk("t1_gnt_latency", gc, 1);
        chk("t1_gnt", g, 4'b0001);
        chk("t1_done_latency", dc, 3);
        chk("t1_err", e, 0);
        chk("t1_id", did, 0);
        @(negedge clk);
        chk("t1_cnt", err_cnt, 0);

        // odd parity on requester 2
        run_req(4'b0100, 16'h0700, gc, dc, g, e, did);
        chk("t2_err", e, 1);
        chk("t2_id", did, 2);
        @(negedge clk);
        chk("t2_cnt", err_cnt, 1);
        chk("t2_flag", err_flag, 4'b0100);

        // all requesters held: rotating grants
        do_reset();
        @(negedge clk); #1 req = 4'b1111; data = 16'h1111;
        ng = 0; nd = 0;
        for (int k = 1; k <= 40 && nd < 5; k++) begin
            @(negedge clk);
            if (gnt != 0 && ng < 5) begin
                gid[ng] = oh2i(gnt); gt[ng] = k; ng++;
                if (ng == 5) #1 req = '0;
            end
            if (done) nd++;
        end
        chk("t3_ngrants", ng, 5);
        for (int i = 0; i < 5; i++) chk("t3_order", gid[i], i % 4);
        for (int i = 0; i < 4; i++) chk("t3_spacing", gt[i+1] - gt[i], 4);
        @(negedge clk);
        chk("t3_cnt", err_cnt, 5);
        chk("t3_flag", err_flag, 4'b1111);

        // saturation, then clr racing a failing done
        @(negedge clk); #1 req = 4'b0001; data = 16'h0001;
        nd = 0;
        for (int k = 0; k < 1400 && nd < 300; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("t4_ndone", nd, 300);
        @(negedge clk);
        chk("t4_sat", err_cnt, 255);
        for (int r = 0; r < 2; r++) begin
            nd = 0;
            for (int k = 0; k < 8 && nd == 0; k++) begin
                @(negedge clk);
                if (done) nd = 1;
            end
            chk("t4_done_seen", nd, 1);
            if (r == 0) begin
                #1 clr = 1'b1;
                @(negedge clk);
                chk("t4_clr_cnt", err_cnt, 0);
                chk("t4_clr_flag", err_flag, 0);
                #1 clr = 1'b0;
            end else begin
                @(negedge clk);
                chk("t4_after_cnt", err_cnt, 1);
                chk("t4_after_flag", err_flag, 4'b0001);
            end
        end
        #1 req = '0;
        repeat (6) @(negedge clk);

        // reset during CHECK
        #1 req = 4'b0010; data = 16'h0000;
        gc = -1;
        for (int k = 0; k < 6 && gc < 0; k++) begin
            @(negedge clk);
            if (gnt != 0) gc = k;
        end
        chk("t5_granted", gnt, 4'b0010);
        #1 req = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("t5_rst_outputs", {gnt, done, err, done_id, err_cnt, err_flag}, 0);
        @(negedge clk); #1 rst = 1'b0;
        anyg = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || gnt != 0) anyg++;
        end
        chk("t5_no_done", anyg, 0);
        run_req(4'b0011, 16'h0000, gc, dc, g, e, did);
        chk("t5_rr_restart", g, 4'b0001);

        // req dropped during GRANT; data still captured
        run_req(4'b0010, 16'h00C0, gc, dc, g, e, did);
        chk("t6_err", e, 0);
        chk("t6_id", did, 1);
        anyg = 0;
        repeat (8) begin
            @(negedge clk);
            if (gnt != 0) anyg++;
        end
        chk("t6_no_regrant", anyg, 0);

        // random traffic against the model
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            #1 req = NREQ'($urandom);
            data = 16'($urandom);
            clr = ($urandom_range(0, 15) == 0);
        end
        #1 req = '0; clr = 1'b0;
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, fails);
        $finish;
    end

endmodule
